// File: rtl/alu_dispatch.sv
// Round-robin dispatcher between NCH requesters and a shared keyed ALU.
// Issues one tagged op per cycle, routes keyed results back, frees lost ops on timeout.
module alu_dispatch #(
    parameter int unsigned NCH     = 4,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned OPW     = 8,
    parameter int unsigned KEYW    = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       req_valid,
    output logic [NCH-1:0]       req_ready,
    input  logic [NCH*OPW-1:0]   req_op,
    input  logic [NCH*WIDTH-1:0] req_a,
    input  logic [NCH*WIDTH-1:0] req_b,
    output logic [OPW-1:0]       op_o,
    output logic [KEYW-1:0]      key_o,
    output logic [WIDTH-1:0]     a_o,
    output logic [WIDTH-1:0]     b_o,
    input  logic [KEYW-1:0]      key_i,
    input  logic [WIDTH-1:0]     res_i,
    output logic [NCH-1:0]       res_valid,
    output logic [NCH*WIDTH-1:0] res_data,
    output logic [NCH-1:0]       err
);
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] TMO_MAX = CW'(TIMEOUT);

    logic [NCH-1:0] busy;
    logic [CW-1:0]  cnt [NCH];
    logic [PW-1:0]  ptr;

    logic [NCH-1:0]   gnt_c;
    logic [NCH-1:0]   hit_c;
    logic [NCH-1:0]   tmo_c;
    logic             gnt_any_c;
    logic [PW-1:0]    gnt_idx_c;
    logic [KEYW-1:0]  key_sel_c;
    logic [OPW-1:0]   op_sel_c;
    logic [WIDTH-1:0] a_sel_c;
    logic [WIDTH-1:0] b_sel_c;

    // Round-robin search: channels above the pointer first, then wrap to 0..ptr.
    always_comb begin
        gnt_c     = '0;
        gnt_any_c = 1'b0;
        gnt_idx_c = ptr;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (!gnt_any_c && (c > 32'(ptr)) && req_valid[c] && req_ready[c]) begin
                gnt_any_c = 1'b1;
                gnt_idx_c = PW'(c);
                gnt_c[c]  = 1'b1;
            end
        end
        for (int unsigned c = 0; c < NCH; c++) begin
            if (!gnt_any_c && (c <= 32'(ptr)) && req_valid[c] && req_ready[c]) begin
                gnt_any_c = 1'b1;
                gnt_idx_c = PW'(c);
                gnt_c[c]  = 1'b1;
            end
        end
    end

    // Payload of the granted channel, result hits and timeouts.
    always_comb begin
        key_sel_c = '0;
        op_sel_c  = '0;
        a_sel_c   = '0;
        b_sel_c   = '0;
        hit_c     = '0;
        tmo_c     = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (gnt_c[c]) begin
                key_sel_c = KEYW'(c + 1);
                op_sel_c  = req_op[c*OPW +: OPW];
                a_sel_c   = req_a[c*WIDTH +: WIDTH];
                b_sel_c   = req_b[c*WIDTH +: WIDTH];
            end
            hit_c[c] = busy[c] && (key_i == KEYW'(c + 1));
            // A result arriving on the timeout cycle takes precedence.
            tmo_c[c] = (TIMEOUT != 0) && busy[c] && (cnt[c] == TMO_MAX) && !hit_c[c];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= '0;
            req_ready <= '0;
            ptr       <= PW'(NCH - 1);
            key_o     <= '0;
            op_o      <= '0;
            a_o       <= '0;
            b_o       <= '0;
            res_valid <= '0;
            res_data  <= '0;
            err       <= '0;
            for (int unsigned c = 0; c < NCH; c++) cnt[c] <= '0;
        end else begin
            res_valid <= hit_c;
            err       <= tmo_c;
            key_o     <= gnt_any_c ? key_sel_c : '0;
            if (gnt_any_c) begin
                ptr  <= gnt_idx_c;
                op_o <= op_sel_c;
                a_o  <= a_sel_c;
                b_o  <= b_sel_c;
            end
            for (int unsigned c = 0; c < NCH; c++) begin
                // Ready drops on accept; a busy clear shows up one edge later.
                req_ready[c] <= !busy[c] && !gnt_c[c];
                if (hit_c[c]) res_data[c*WIDTH +: WIDTH] <= res_i;
                if (gnt_c[c]) begin
                    busy[c] <= 1'b1;
                    cnt[c]  <= '0;
                end else if (hit_c[c] || tmo_c[c]) begin
                    busy[c] <= 1'b0;
                    cnt[c]  <= '0;
                end else if (busy[c] && (cnt[c] != TMO_MAX)) begin
                    cnt[c] <= cnt[c] + CW'(1);
                end
            end
        end
    end
endmodule

// File: doc/alu_dispatch.md
# alu_dispatch

Parametrised N-channel dispatcher that sits between independent requesters and the shared keyed 32-bit ALU. It arbitrates requests round-robin and issues one tagged operation per cycle. Results returning on the ALU key/result bus are routed back to the originating channel. A per-channel timeout frees a channel whose result is lost. It generalises the fixed two-input key multiplexer with handshakes, outstanding-operation tracking, result return and error reporting.

## Interface
- NCH, 4, number of requester channels (1..255)
- WIDTH, 32, operand/result width
- OPW, 8, opcode width (codes as defined in config.vh)
- KEYW, 8, key width; must satisfy 2^KEYW > NCH
- TIMEOUT, 255, cycles allowed from issue to result; 0 disables timeout

Ports:
- clk  in  1  system clock (single clock domain)
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NCH  per-channel request valid
- req_ready  out  NCH  per-channel ready (registered)
- req_op  in  NCH*OPW  flattened opcodes; channel i at [i*OPW +: OPW]
- req_a  in  NCH*WIDTH  flattened operand A
- req_b  in  NCH*WIDTH  flattened operand B
- op_o  out  OPW  issued opcode to ALU
- key_o  out  KEYW  issued key; 0 = no operation this cycle
- a_o, b_o  out  WIDTH  issued operands
- key_i  in  KEYW  key returned by ALU with result; 0 = none
- res_i  in  WIDTH  ALU result
- res_valid  out  NCH  one-cycle result pulse per channel
- res_data  out  NCH*WIDTH  flattened per-channel result, held until next result
- err  out  NCH  one-cycle timeout pulse per channel

## Operation
- Channel i is assigned fixed key i+1; key 0 is reserved for idle.
- Per-channel state: busy flag, timeout counter of ceil(log2(TIMEOUT+1)) bits.
- req_ready[i] = registered ~busy[i]. A request is accepted at the clock edge where req_valid[i] & req_ready[i] and channel i holds the grant.
- Arbitration: round-robin pointer, initialised to NCH-1. Each cycle, pick the first channel with valid&ready, searching from pointer+1 with wrap to 0. At most one grant per cycle. The pointer moves to the granted channel and is unchanged if there is no grant.
- On grant: op_o/a_o/b_o/key_o load the channel's op/A/B and key i+1; busy[i] is set; counter[i] is cleared. With no grant, key_o=0 and op_o/a_o/b_o hold their previous values.
- Result: key_i in 1..NCH with busy[key_i-1] set → res_data[k] <= res_i, res_valid[k] pulses, busy clears. key_i=0, out-of-range, or matching a non-busy channel → ignored, no output change.
- Timeout (TIMEOUT>0): the counter increments each cycle while busy. When the counter reaches TIMEOUT with no matching result that cycle, err pulses, busy clears and the counter resets. A late result for that channel is then ignored.
- If a result and a timeout hit the same channel in the same cycle, the result wins and err stays low.
- A result and a grant on different channels in the same cycle are both processed.
- Reset: all registers cleared asynchronously. req_ready=0 during reset and all ones on the first edge after release. key_o=0, op_o/a_o/b_o=0, res_valid=0, err=0, res_data=0, busy=0, pointer=NCH-1. Results arriving after reset are ignored.

## Timing
- Request accept → key_o/op_o/a_o/b_o valid: 1 cycle (registered, after the accepting edge). key_o is nonzero for exactly one cycle per issue.
- req_ready[i] falls on the accepting edge. The channel cannot issue again until at least 1 cycle after its result edge: the busy clear is visible to ready at the next edge.
- key_i/res_i sampled at edge t → res_valid/res_data visible after edge t; pulse lasts one cycle.
- Timeout: err asserted at edge issue+TIMEOUT+1 if no result was seen by edge issue+TIMEOUT.
- Max throughput: one issue per cycle across channels; one outstanding op per channel.

## Test plan
- Single request: ch0 op=ADD, A=ffc6b000, B=ffd4d800. Expect key_o=1 for one cycle; return key_i=1, res_i=ff9b8800 → res_valid[0] pulse, res_data[0]=ff9b8800, req_ready[0] high again.
- All four channels valid simultaneously from reset. Expect issue order keys 1,2,3,4 on consecutive cycles. Then with ch1 and ch3 re-requesting after their results, the next grant order follows the pointer (ch3 before ch1 if the pointer sits at 2).
- Out-of-order return: issue ch0 (MUL) then ch2 (ADD), return key 3 before key 1. Each res_data is routed to the correct channel; key_i=7 and key_i=0 cause no res_valid.
- Timeout with TIMEOUT=4: issue ch1, never return. err[1] pulses exactly once, 5 cycles after issue, and req_ready[1] rises. A late key_i=2 is ignored.
- Race: TIMEOUT=4 with key_i=2 presented on the exact timeout cycle. Expect res_valid[1]=1 and err[1]=0.
- Reset mid-operation: assert rst asynchronously with ch0 and ch2 busy. Outputs go to 0 immediately. After release, all ready; a stale key_i=1 produces no res_valid.
